mux_arb_n: RTL and testbench

//  Parametrised, registered N-channel W-bit multiplexer; successor to the 2:1 combinational mux.

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux_arb_n_rr_arbiter.sv | 38 +++
 rtl/mux_arb_n.sv | 64 ++++++
 tb/tb_mux_arb_n.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel registered arbitrating mux.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// Priority logic: fixed (lowest index first) or round-robin starting after ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  logic found;

  // Walk candidates in priority order; the first requester seen wins.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = (mode == MODE_RR) ? (int'(ptr) + 1 + k) % N : k;
      if (!found && req[idx[SEL_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel valid/ready arbiter feeding one registered output slot.
module mux_arb_n
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int SEL_W = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  logic [W-1:0]     ch_data [N];
  logic [SEL_W-1:0] ptr_reg;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             slot_free;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*W +: W];
    end
  endgenerate

  assign slot_free = ~out_valid | out_ready;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_reg),
    .mode    (mode),
    .en      (slot_free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // gnt is already gated by slot_free, so it is exactly the accept vector.
  assign in_ready = gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_reg   <= SEL_W'(N - 1);
    end else if (|gnt) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[gnt_idx];
      out_sel   <= gnt_idx;
      ptr_reg   <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n (N=4, W=8) with a reference grant model.
module tb_mux_arb_n;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic [3:0]   in_valid;
  logic [31:0]  in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  logic [7:0] ch_val [4];

  typedef struct {
    int         sel;
    logic [7:0] data;
  } entry_t;

  entry_t sb[$];
  int     m_ptr;
  logic   m_valid;
  int     errs;
  int     checks;

  mux_arb_n #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, act, $time);
    end
  endtask

  function automatic int model_grant(input logic md, input logic [3:0] v, input int p);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = md ? (p + 1 + k) % 4 : k;
      if (((v >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 3;
    sb.delete();
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input int exp_sel);
    int     g;
    logic   free;
    logic [3:0] exp_rdy;
    entry_t e;
    in_data = {ch_val[3], ch_val[2], ch_val[1], ch_val[0]};
    #1;
    g       = model_grant(mode, in_valid, m_ptr);
    free    = !m_valid || out_ready;
    exp_rdy = (g >= 0 && free) ? 4'(1 << g) : 4'd0;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(0), 32'(1));
      end else begin
        e = sb[0];
        check("out_sel", 32'(out_sel), 32'(e.sel));
        check("out_data", 32'(out_data), 32'(e.data));
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (exp_rdy != 4'd0) begin
      e.sel  = g;
      e.data = ch_val[g];
      sb.push_back(e);
      m_valid = 1'b1;
      m_ptr   = g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (exp_sel >= 0) check("seq_sel", 32'(out_sel), 32'(exp_sel));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = 4'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) ch_val[i] = 8'(8'h10 * (i + 1));
    in_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    rst_n = 1'b1;

    // Async reset mid-cycle while the slot is full.
    ch_val[1] = 8'h3C;
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    cycle(1);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_data", 32'(out_data), 32'd0);
    check("async_out_sel", 32'(out_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;

    // Single channel.
    in_valid  = 4'b0100;
    ch_val[2] = 8'hA5;
    cycle(2);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hA5);
    in_valid = 4'd0;
    cycle(-1);

    // Fixed priority.
    mode     = 1'b0;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) cycle(0);
    in_valid = 4'd0;
    cycle(-1);

    // Round-robin fairness after reset.
    do_reset();
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 4; c++) ch_val[c] = 8'($urandom_range(0, 255));
      cycle(i % 4);
    end
    in_valid = 4'b1010;
    cycle(1);
    cycle(3);
    cycle(1);
    cycle(3);
    in_valid = 4'd0;
    cycle(-1);

    // Backpressure then simultaneous drain and refill.
    in_valid  = 4'b0011;
    out_ready = 1'b1;
    cycle(-1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle(-1);
    out_ready = 1'b1;
    cycle(-1);
    check("no_bubble", 32'(out_valid), 32'd1);
    in_valid = 4'd0;
    cycle(-1);

    // Mode switch keeps ptr.
    do_reset();
    mode     = 1'b1;
    in_valid = 4'b0100;
    cycle(2);
    mode     = 1'b0;
    in_valid = 4'b1001;
    cycle(0);
    mode = 1'b1;
    cycle(3);
    in_valid = 4'd0;
    cycle(-1);

    // Random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      mode      = 1'($urandom_range(0, 1));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) ch_val[c] = 8'($urandom_range(0, 255));
      cycle(-1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
